// File: rtl/axil_ctrl_master.sv
// AXI4-Lite initiator for a tile's control_S_AXI port.
// Takes one command at a time, runs the AW/W/B or AR/R exchange and returns a
// single response. A saturating wait counter aborts a transaction the slave
// never finishes.
module axil_ctrl_master #(
  parameter int BW       = 32,
  parameter int BWB      = BW/8,
  parameter int AXI_ADDR = 8,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic                clk_control,
  input  logic                clk_control_rst_high,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_ADDR-1:0] cmd_addr,
  input  logic [BW-1:0]       cmd_wdata,
  input  logic [BWB-1:0]      cmd_wstrb,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BW-1:0]       rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                err_sticky,
  // AXI4-Lite master
  output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
  output logic                control_M_AXI_AWVALID,
  input  logic                control_M_AXI_AWREADY,
  output logic [BW-1:0]       control_M_AXI_WDATA,
  output logic [BWB-1:0]      control_M_AXI_WSTRB,
  output logic                control_M_AXI_WVALID,
  input  logic                control_M_AXI_WREADY,
  input  logic [1:0]          control_M_AXI_BRESP,
  input  logic                control_M_AXI_BVALID,
  output logic                control_M_AXI_BREADY,
  output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
  output logic                control_M_AXI_ARVALID,
  input  logic                control_M_AXI_ARREADY,
  input  logic [BW-1:0]       control_M_AXI_RDATA,
  input  logic [1:0]          control_M_AXI_RRESP,
  input  logic                control_M_AXI_RVALID,
  output logic                control_M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  // registered AXI handshake outputs
  typedef struct packed {
    logic awvalid;
    logic wvalid;
    logic bready;
    logic arvalid;
    logic rready;
  } hs_t;

  // registered response payload
  typedef struct packed {
    logic          valid;
    logic [BW-1:0] rdata;
    logic [1:0]    resp;
    logic          timeout;
  } rsp_t;

  state_t              state, state_d;
  hs_t                 hs, hs_d;
  rsp_t                rsp, rsp_d;
  logic [AXI_ADDR-1:0] awaddr, awaddr_d;
  logic [AXI_ADDR-1:0] araddr, araddr_d;
  logic [BW-1:0]       wdata, wdata_d;
  logic [BWB-1:0]      wstrb, wstrb_d;
  logic                err, err_d;
  logic [TO_W-1:0]     cnt, cnt_d;
  logic                abort;

  logic active, expired, aw_done, w_done;

  assign active  = (state == WR) || (state == WR_RESP) ||
                   (state == RD_ADDR) || (state == RD_DATA);
  assign expired = active && (cnt == TO_W'(TIMEOUT));
  // a channel counts as done once its valid is low or handshakes this edge
  assign aw_done = !hs.awvalid || control_M_AXI_AWREADY;
  assign w_done  = !hs.wvalid  || control_M_AXI_WREADY;

  assign cmd_ready   = (state == IDLE) && !clk_control_rst_high;
  assign busy        = (state != IDLE);
  assign err_sticky  = err;
  assign rsp_valid   = rsp.valid;
  assign rsp_rdata   = rsp.rdata;
  assign rsp_resp    = rsp.resp;
  assign rsp_timeout = rsp.timeout;

  assign control_M_AXI_AWADDR  = awaddr;
  assign control_M_AXI_AWVALID = hs.awvalid;
  assign control_M_AXI_WDATA   = wdata;
  assign control_M_AXI_WSTRB   = wstrb;
  assign control_M_AXI_WVALID  = hs.wvalid;
  assign control_M_AXI_BREADY  = hs.bready;
  assign control_M_AXI_ARADDR  = araddr;
  assign control_M_AXI_ARVALID = hs.arvalid;
  assign control_M_AXI_RREADY  = hs.rready;

  // next-state and next-output logic; every AXI output is a register
  always_comb begin
    state_d  = state;
    hs_d     = hs;
    rsp_d    = rsp;
    awaddr_d = awaddr;
    araddr_d = araddr;
    wdata_d  = wdata;
    wstrb_d  = wstrb;
    err_d    = err;
    cnt_d    = cnt;
    abort    = 1'b0;

    // saturate rather than wrap so a stuck slave can never re-arm the wait
    if (active && (cnt != {TO_W{1'b1}})) cnt_d = cnt + 1'b1;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cnt_d = '0;
          if (cmd_write) begin
            awaddr_d     = cmd_addr;
            wdata_d      = cmd_wdata;
            wstrb_d      = cmd_wstrb;
            hs_d.awvalid = 1'b1;
            hs_d.wvalid  = 1'b1;
            state_d      = WR;
          end else begin
            araddr_d     = cmd_addr;
            hs_d.arvalid = 1'b1;
            state_d      = RD_ADDR;
          end
        end
      end
      WR: begin
        if (hs.awvalid && control_M_AXI_AWREADY) hs_d.awvalid = 1'b0;
        if (hs.wvalid  && control_M_AXI_WREADY)  hs_d.wvalid  = 1'b0;
        if (aw_done && w_done) begin
          hs_d.bready = 1'b1;
          state_d     = WR_RESP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (control_M_AXI_BVALID) begin
          hs_d.bready   = 1'b0;
          rsp_d.valid   = 1'b1;
          rsp_d.rdata   = '0;
          rsp_d.resp    = control_M_AXI_BRESP;
          rsp_d.timeout = 1'b0;
          err_d         = err || (control_M_AXI_BRESP != 2'b00);
          state_d       = RSP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        // RREADY stays low here, so an early RVALID is not taken
        if (control_M_AXI_ARREADY) begin
          hs_d.arvalid = 1'b0;
          hs_d.rready  = 1'b1;
          state_d      = RD_DATA;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RD_DATA: begin
        if (control_M_AXI_RVALID) begin
          hs_d.rready   = 1'b0;
          rsp_d.valid   = 1'b1;
          rsp_d.rdata   = control_M_AXI_RDATA;
          rsp_d.resp    = control_M_AXI_RRESP;
          rsp_d.timeout = 1'b0;
          err_d         = err || (control_M_AXI_RRESP != 2'b00);
          state_d       = RSP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_d.valid = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // abandon the AXI exchange and report a SLVERR-coded timeout
    if (abort) begin
      hs_d          = '0;
      rsp_d.valid   = 1'b1;
      rsp_d.rdata   = '0;
      rsp_d.resp    = 2'b10;
      rsp_d.timeout = 1'b1;
      err_d         = 1'b1;
      state_d       = RSP;
    end
  end

  // state and output registers; reset discards any outstanding transaction
  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) begin
      state  <= IDLE;
      hs     <= '0;
      rsp    <= '0;
      awaddr <= '0;
      araddr <= '0;
      wdata  <= '0;
      wstrb  <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      hs     <= hs_d;
      rsp    <= rsp_d;
      awaddr <= awaddr_d;
      araddr <= araddr_d;
      wdata  <= wdata_d;
      wstrb  <= wstrb_d;
      err    <= err_d;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Bench for axil_ctrl_master: a delay-configurable AXI4-Lite memory slave,
// a protocol monitor, and scenario tasks checked against a word-array model.
module tb_axil_ctrl_master;
  localparam int BW = 32, BWB = 4, AW = 8, TMO = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_wdata = '0;
  logic [BWB-1:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy, err_sticky;
  logic [BW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [BW-1:0] wdata, rdata = '0;
  logic [BWB-1:0] wstrb;
  logic [1:0] bresp = '0, rresp = '0;

  axil_ctrl_master #(.BW(BW), .BWB(BWB), .AXI_ADDR(AW), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk_control(clk), .clk_control_rst_high(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy), .err_sticky(err_sticky),
    .control_M_AXI_AWADDR(awaddr), .control_M_AXI_AWVALID(awvalid), .control_M_AXI_AWREADY(awready),
    .control_M_AXI_WDATA(wdata), .control_M_AXI_WSTRB(wstrb), .control_M_AXI_WVALID(wvalid),
    .control_M_AXI_WREADY(wready),
    .control_M_AXI_BRESP(bresp), .control_M_AXI_BVALID(bvalid), .control_M_AXI_BREADY(bready),
    .control_M_AXI_ARADDR(araddr), .control_M_AXI_ARVALID(arvalid), .control_M_AXI_ARREADY(arready),
    .control_M_AXI_RDATA(rdata), .control_M_AXI_RRESP(rresp), .control_M_AXI_RVALID(rvalid),
    .control_M_AXI_RREADY(rready)
  );

  int checks = 0, passes = 0;

  // ---------------- slave: ready/valid after a programmable number of cycles
  bit slv_en = 1'b1;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_k = 2'b00, r_resp_k = 2'b00;
  logic [31:0] smem [0:63];
  bit aw_got, w_got, ar_got, b_started;
  bit pend_aw, pend_w, pend_b, pend_ar, pend_r;
  int aw_c, w_c, b_c, ar_c, r_c;
  logic [7:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0] s_wstrb;

  task automatic slave_reset();
    aw_got = 0; w_got = 0; ar_got = 0; b_started = 0;
    pend_aw = 0; pend_w = 0; pend_b = 0; pend_ar = 0; pend_r = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  // inputs change on the falling edge; pend_* record what the next rising edge will handshake
  initial begin
    slave_reset();
    for (int i = 0; i < 64; i++) smem[i] = '0;
    forever begin
      @(negedge clk);
      if (slv_en) begin
        if (pend_aw) begin aw_got = 1; aw_c = 0; end
        if (pend_w)  begin w_got = 1; w_c = 0; end
        if (pend_b)  begin bvalid = 0; b_started = 0; aw_got = 0; w_got = 0; b_c = 0; end
        if (pend_ar) begin ar_got = 1; ar_c = 0; end
        if (pend_r)  begin rvalid = 0; ar_got = 0; r_c = 0; end
        if (aw_got && w_got && !b_started) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) smem[s_awaddr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
          b_started = 1; b_c = 0;
        end
        awready = 0;
        if (awvalid && !aw_got) begin if (aw_c >= aw_dly) awready = 1; else aw_c++; end
        wready = 0;
        if (wvalid && !w_got) begin if (w_c >= w_dly) wready = 1; else w_c++; end
        if (b_started && !bvalid) begin
          if (b_c >= b_dly) begin bvalid = 1; bresp = b_resp_k; end else b_c++;
        end
        arready = 0;
        if (arvalid && !ar_got) begin if (ar_c >= ar_dly) arready = 1; else ar_c++; end
        if (ar_got && !rvalid) begin
          if (r_c >= r_dly) begin rvalid = 1; rdata = smem[s_araddr[7:2]]; rresp = r_resp_k; end
          else r_c++;
        end
        pend_aw = awvalid && awready; if (pend_aw) s_awaddr = awaddr;
        pend_w  = wvalid && wready;   if (pend_w) begin s_wdata = wdata; s_wstrb = wstrb; end
        pend_b  = bvalid && bready;
        pend_ar = arvalid && arready; if (pend_ar) s_araddr = araddr;
        pend_r  = rvalid && rready;
      end
    end
  end

  // ---------------- monitor: valid-high cycle counts and protocol violations
  int aw_hi = 0, w_hi = 0, ar_hi = 0, viol = 0, rsp_rise = 0;
  logic p_aw = 0, p_w = 0, p_ar = 0, p_rv = 0;
  logic [7:0] p_awa = '0, p_ara = '0;
  logic [31:0] p_wd = '0;
  logic [3:0] p_ws = '0;
  initial forever begin
    @(posedge clk); #1;
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (arvalid) ar_hi++;
    if (bready && (awvalid || wvalid)) viol++;
    if (rready && arvalid) viol++;
    if (p_aw && awvalid && !awready && awaddr !== p_awa) viol++;
    if (p_w && wvalid && !wready && {wdata, wstrb} !== {p_wd, p_ws}) viol++;
    if (p_ar && arvalid && !arready && araddr !== p_ara) viol++;
    if (rsp_valid && !p_rv) rsp_rise++;
    p_aw = awvalid; p_w = wvalid; p_ar = arvalid; p_rv = rsp_valid;
    p_awa = awaddr; p_ara = araddr; p_wd = wdata; p_ws = wstrb;
  end

  task automatic clr_mon();
    @(negedge clk);
    aw_hi = 0; w_hi = 0; ar_hi = 0; viol = 0;
  endtask

  // issue one command, optionally stall the response hold cycles, then consume it
  task automatic run_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output logic [31:0] rd, output logic [1:0] rr, output logic to,
                         output bit ok, output int hold_bad);
    int n;
    ok = 1; hold_bad = 0; rd = 'x; rr = 'x; to = 'x;
    @(posedge clk); #1;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) ok = 0;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin ok = 0; return; end
    rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || {rsp_rdata, rsp_resp, rsp_timeout} !== {rd, rr, to}) hold_bad++;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready_in_reset: got %b want 0", cmd_ready); else passes++;
    rst = 0; #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy, err_sticky} !== 9'b0)
      $display("FAIL rst_flags: got %b want 0", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, busy, err_sticky});
    else passes++;
    checks++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp} !== '0)
      $display("FAIL rst_payload: got %h want 0", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp});
    else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready_after: got %b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_write_basic();
    logic [31:0] rd; logic [1:0] rr; logic to; bit ok; int hb;
    aw_dly = 0; w_dly = 0; b_dly = 1; b_resp_k = 2'b00;
    clr_mon();
    run_cmd(1, 8'h04, 32'h0000_00A5, 4'hF, 0, rd, rr, to, ok, hb);
    checks++; if (ok !== 1'b1) $display("FAIL wr_basic_done: got %b want 1", ok); else passes++;
    checks++; if ({aw_hi, w_hi} !== {32'd1, 32'd1}) $display("FAIL wr_basic_valid_cycles: got aw=%0d w=%0d want 1 1", aw_hi, w_hi); else passes++;
    checks++; if ({rd, rr, to} !== {32'h0, 2'b00, 1'b0}) $display("FAIL wr_basic_rsp: got %h/%b/%b want 0/00/0", rd, rr, to); else passes++;
    checks++; if (err_sticky !== 1'b0) $display("FAIL wr_basic_err: got %b want 0", err_sticky); else passes++;
    checks++; if (smem[1] !== 32'h0000_00A5) $display("FAIL wr_basic_mem: got %h want 000000a5", smem[1]); else passes++;
    checks++; if (viol !== 0) $display("FAIL wr_basic_protocol: got %0d want 0", viol); else passes++;
  endtask

  task automatic test_write_w_first();
    logic [31:0] rd; logic [1:0] rr; logic to; bit ok; int hb, r0;
    aw_dly = 3; w_dly = 0; b_dly = 0;
    clr_mon();
    r0 = rsp_rise;
    run_cmd(1, 8'h10, 32'hDEAD_BEEF, 4'h5, 0, rd, rr, to, ok, hb);
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({aw_hi, w_hi} !== {32'd4, 32'd1}) $display("FAIL wr_wfirst_cycles: got aw=%0d w=%0d want 4 1", aw_hi, w_hi); else passes++;
    checks++; if (viol !== 0) $display("FAIL wr_wfirst_protocol: got %0d want 0", viol); else passes++;
    checks++; if (rsp_rise - r0 !== 1) $display("FAIL wr_wfirst_rsp_count: got %0d want 1", rsp_rise - r0); else passes++;
    checks++; if ({ok, rr} !== {1'b1, 2'b00}) $display("FAIL wr_wfirst_rsp: got ok=%b resp=%b want 1 00", ok, rr); else passes++;
  endtask

  task automatic test_read();
    logic [31:0] rd; logic [1:0] rr; logic to; bit ok; int hb;
    aw_dly = 0; w_dly = 0; ar_dly = 2; r_dly = 0; r_resp_k = 2'b00;
    smem[2] = 32'h1234_5678;
    clr_mon();
    run_cmd(0, 8'h08, 32'h0, 4'h0, 0, rd, rr, to, ok, hb);
    checks++; if ({ok, rd, rr, to} !== {1'b1, 32'h1234_5678, 2'b00, 1'b0}) $display("FAIL rd_rsp: got ok=%b %h/%b/%b want 1 12345678/00/0", ok, rd, rr, to); else passes++;
    checks++; if (ar_hi !== 3) $display("FAIL rd_ar_cycles: got %0d want 3", ar_hi); else passes++;
    checks++; if (viol !== 0) $display("FAIL rd_protocol: got %0d want 0", viol); else passes++;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$]; int cyc, r0, n; logic rdy;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_k = 2'b00;
    r0 = rsp_rise; cyc = 0; n = 0;
    @(posedge clk); #1;
    rsp_ready = 1; cmd_write = 1; cmd_wstrb = 4'hF;
    cmd_addr = 8'h20; cmd_wdata = 32'hB0B0_0000; cmd_valid = 1;
    while (acc_cyc.size() < 3 && cyc < 60) begin
      rdy = cmd_ready;
      @(posedge clk); #1; cyc++;
      if (rdy) begin
        acc_cyc.push_back(cyc); n++;
        cmd_addr = 8'h20 + 8'(4 * n); cmd_wdata = 32'hB0B0_0000 + n;
        if (acc_cyc.size() == 3) cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    repeat (6) @(posedge clk);
    #1; rsp_ready = 0;
    checks++; if (acc_cyc.size() !== 3) $display("FAIL b2b_accepts: got %0d want 3", acc_cyc.size());
    else begin
      passes++;
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 4) $display("FAIL b2b_gap0: got %0d want 4", acc_cyc[1] - acc_cyc[0]); else passes++;
      checks++; if (acc_cyc[2] - acc_cyc[1] !== 4) $display("FAIL b2b_gap1: got %0d want 4", acc_cyc[2] - acc_cyc[1]); else passes++;
    end
    checks++; if (rsp_rise - r0 !== 3) $display("FAIL b2b_rsp_count: got %0d want 3", rsp_rise - r0); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:63];
    logic [31:0] rd, exp_rd, d; logic [1:0] rr, exp_rr; logic to; bit ok, exp_err; int hb, bad;
    logic [7:0] a; logic [3:0] s; bit wr;
    for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; smem[i] = '0; end
    exp_err = 1'b0; bad = 0;
    clr_mon();
    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      wr = $urandom_range(0, 1) == 1;
      a = 8'($urandom_range(0, 15) * 4); d = $urandom; s = 4'($urandom_range(0, 15));
      b_resp_k = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_resp_k = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (wr) begin
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a >> 2][8*i +: 8] = d[8*i +: 8];
        exp_rd = '0; exp_rr = b_resp_k;
      end else begin
        exp_rd = ref_mem[a >> 2]; exp_rr = r_resp_k;
      end
      if (exp_rr != 2'b00) exp_err = 1'b1;
      run_cmd(wr, a, d, s, $urandom_range(0, 2), rd, rr, to, ok, hb);
      checks++;
      if ({ok, rd, rr, to, hb} !== {1'b1, exp_rd, exp_rr, 1'b0, 32'd0}) begin
        $display("FAIL rand_txn%0d: got ok=%b %h/%b/%b hold=%0d want 1 %h/%b/0 0", t, ok, rd, rr, to, hb, exp_rd, exp_rr);
        bad++;
      end else passes++;
    end
    checks++; if (err_sticky !== exp_err) $display("FAIL rand_err_sticky: got %b want %b", err_sticky, exp_err); else passes++;
    checks++; if (viol !== 0) $display("FAIL rand_protocol: got %0d want 0", viol); else passes++;
    b_resp_k = 2'b00; r_resp_k = 2'b00;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic [1:0] rr; logic to; bit ok; int hb, r0, bad;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 1000; r_dly = 0;
    clr_mon();
    run_cmd(0, 8'h0C, 32'h0, 4'h0, 0, rd, rr, to, ok, hb);
    checks++; if ({ok, rd, rr, to} !== {1'b1, 32'h0, 2'b10, 1'b1}) $display("FAIL tmo_rsp: got ok=%b %h/%b/%b want 1 0/10/1", ok, rd, rr, to); else passes++;
    checks++; if (ar_hi !== TMO + 1) $display("FAIL tmo_ar_cycles: got %0d want %0d", ar_hi, TMO + 1); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_sticky); else passes++;
    // late read data must be ignored
    slv_en = 0; slave_reset();
    r0 = rsp_rise; bad = 0;
    rdata = 32'hBAD0_0001; rresp = 2'b00; rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rready || rsp_valid || arvalid) bad++;
    end
    rvalid = 0;
    checks++; if ({bad, rsp_rise - r0} !== {32'd0, 32'd0}) $display("FAIL tmo_late_r: got bad=%0d rsp=%0d want 0 0", bad, rsp_rise - r0); else passes++;
    slave_reset(); slv_en = 1; ar_dly = 0;
    run_cmd(1, 8'h30, 32'h0000_0077, 4'hF, 0, rd, rr, to, ok, hb);
    checks++; if ({ok, rr, to} !== {1'b1, 2'b00, 1'b0}) $display("FAIL tmo_next_cmd: got ok=%b %b/%b want 1 00/0", ok, rr, to); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL tmo_err_held: got %b want 1", err_sticky); else passes++;
  endtask

  task automatic test_resp_hold();
    logic [31:0] rd; logic [1:0] rr; logic to; bit ok; int hb;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp_k = 2'b10;
    run_cmd(1, 8'h14, 32'h5555_AAAA, 4'hF, 5, rd, rr, to, ok, hb);
    checks++; if ({ok, rr, to} !== {1'b1, 2'b10, 1'b0}) $display("FAIL hold_rsp: got ok=%b %b/%b want 1 10/0", ok, rr, to); else passes++;
    checks++; if (hb !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", hb); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL hold_err: got %b want 1", err_sticky); else passes++;
    b_resp_k = 2'b00;
  endtask

  task automatic test_reset_mid();
    int r0, bad;
    aw_dly = 1000; w_dly = 1000;
    r0 = rsp_rise; bad = 0;
    @(posedge clk); #1;
    cmd_write = 1; cmd_addr = 8'h18; cmd_wdata = 32'h1; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    checks++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL rstmid_pre: got %b want 11", {awvalid, wvalid}); else passes++;
    rst = 1;
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, busy} !== 6'b0) $display("FAIL rstmid_valids: got %b want 0", {awvalid, wvalid, bready, arvalid, rready, busy}); else passes++;
    rst = 0; #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready); else passes++;
    slave_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy || awvalid || wvalid) bad++;
    end
    checks++; if ({bad, rsp_rise - r0} !== {32'd0, 32'd0}) $display("FAIL rstmid_no_rsp: got bad=%0d rsp=%0d want 0 0", bad, rsp_rise - r0); else passes++;
    checks++; if (err_sticky !== 1'b0) $display("FAIL rstmid_err_cleared: got %b want 0", err_sticky); else passes++;
    aw_dly = 0; w_dly = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_read();
    test_back_to_back();
    test_random();
    test_timeout();
    test_resp_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // hard stop in case a scenario stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got stall want completion");
    $fatal(1);
  end

endmodule
